// File: rtl/sysarr_pkg.sv
// Shared types and sizing for the systolic array sequencer.
package sysarr_pkg;

  localparam int ARRAY_N_DFLT = 16;
  localparam int ADDR_W_DFLT  = 8;
  localparam int RD_LAT       = 1;
  localparam int DRAIN_LAT    = 2 * ARRAY_N_DFLT;

  // Counter must hold both a row index and the full drain length.
  function automatic int cnt_width(int addr_w, int n);
    int c;
    c = $clog2(2 * n + 1);
    return (addr_w > c) ? addr_w : c;
  endfunction

  localparam int CNT_W = cnt_width(ADDR_W_DFLT, ARRAY_N_DFLT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    COMPUTE,
    DRAIN,
    DONE
  } sysarr_state_t;

endpackage

// File: rtl/sysarr_delay.sv
// Fixed-depth shift register matching the array's output latency; turns the
// delayed active strobe and row offset into an output-buffer write.
module sysarr_delay #(
  parameter int DEPTH = 32,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vld,
  input  logic [W-1:0] off,
  input  logic [W-1:0] base,
  output logic         wr_en,
  output logic [W-1:0] addr
);

  logic [DEPTH-1:0] vld_sr;
  logic [W-1:0]     off_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr <= '0;
      for (int i = 0; i < DEPTH; i++) off_sr[i] <= '0;
    end else begin
      vld_sr    <= {vld_sr[DEPTH-2:0], vld};
      off_sr[0] <= off;
      for (int i = 1; i < DEPTH; i++) off_sr[i] <= off_sr[i-1];
    end
  end

  assign wr_en = vld_sr[DEPTH-1];
  assign addr  = wr_en ? (base + off_sr[DEPTH-1]) : '0;

endmodule

// File: rtl/sysarr_ctrl.sv
// Sequencer for the N x N systolic array: weight preload, input streaming and
// output-write scheduling for one command at a time.
module sysarr_ctrl
  import sysarr_pkg::*;
#(
  parameter int ARRAY_N = ARRAY_N_DFLT,
  parameter int ADDR_W  = ADDR_W_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic [ADDR_W-1:0] weight_base,
  input  logic [ADDR_W-1:0] input_base,
  input  logic [ADDR_W-1:0] output_base,
  output logic              busy,
  output logic              done,
  output logic              wmem_rd_en,
  output logic [ADDR_W-1:0] wmem_addr,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              wwrite,
  output logic              active,
  output logic              omem_wr_en,
  output logic [ADDR_W-1:0] omem_addr
);

  localparam int CW    = cnt_width(ADDR_W, ARRAY_N);
  localparam int DEPTH = 2 * ARRAY_N;

  sysarr_state_t     state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nx;
  logic [ADDR_W-1:0] m_q, wb_q, ib_q, ob_q;
  logic [ADDR_W-1:0] act_off;

  assign cnt_nx = cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      m_q        <= '0;
      wb_q       <= '0;
      ib_q       <= '0;
      ob_q       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wmem_rd_en <= 1'b0;
      wmem_addr  <= '0;
      imem_rd_en <= 1'b0;
      imem_addr  <= '0;
      wwrite     <= 1'b0;
      active     <= 1'b0;
      act_off    <= '0;
    end else begin
      // Buffer read data lands one cycle after the enable.
      wwrite  <= wmem_rd_en;
      active  <= imem_rd_en;
      act_off <= (state == COMPUTE) ? ADDR_W'(cnt) : '0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_q  <= num_rows;
            wb_q <= weight_base;
            ib_q <= input_base;
            ob_q <= output_base;
            cnt  <= '0;
            if (num_rows == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= LOAD_W;
              busy       <= 1'b1;
              wmem_rd_en <= 1'b1;
              wmem_addr  <= weight_base;
            end
          end
        end
        LOAD_W: begin
          if (cnt == CW'(ARRAY_N - 1)) begin
            state      <= COMPUTE;
            cnt        <= '0;
            wmem_rd_en <= 1'b0;
            wmem_addr  <= '0;
            imem_rd_en <= 1'b1;
            imem_addr  <= ib_q;
          end else begin
            cnt       <= cnt_nx;
            wmem_addr <= wb_q + ADDR_W'(cnt_nx);
          end
        end
        COMPUTE: begin
          if (cnt_nx == CW'(m_q)) begin
            state      <= DRAIN;
            cnt        <= '0;
            imem_rd_en <= 1'b0;
            imem_addr  <= '0;
          end else begin
            cnt       <= cnt_nx;
            imem_addr <= ib_q + ADDR_W'(cnt_nx);
          end
        end
        DRAIN: begin
          // Stay until the final row has left the delay line.
          if (cnt == CW'(DEPTH)) begin
            state <= DONE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt_nx;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sysarr_delay #(
    .DEPTH(DEPTH),
    .W    (ADDR_W)
  ) u_delay (
    .clk  (clk),
    .reset(reset),
    .vld  (active),
    .off  (act_off),
    .base (ob_q),
    .wr_en(omem_wr_en),
    .addr (omem_addr)
  );

endmodule

// File: doc/sysarr_ctrl.md
# sysarr_ctrl

Sequencer for the N x N systolic PE array. On a start pulse it preloads one N-row weight tile into the array through the PE weight-shift chain (`wwrite`), then streams M input rows with `active` asserted and schedules the output-memory writes for the M result rows. It sits between the host/command interface and the array, and drives the weight, input and output buffer address ports directly.

## Interface
- `ARRAY_N`, 16: array dimension; also the number of weight rows per tile.
- `ADDR_W`, 8: buffer address width; also the width of `num_rows`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle command strobe; sampled only in IDLE.
- `num_rows`  in  ADDR_W  M, the input row count; captured when `start` is accepted.
- `weight_base`, `input_base`, `output_base`  in  ADDR_W each  buffer base addresses; captured when `start` is accepted.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `wmem_rd_en`  out  1  weight buffer read enable.
- `wmem_addr`  out  ADDR_W  weight buffer read address.
- `imem_rd_en`  out  1  input buffer read enable.
- `imem_addr`  out  ADDR_W  input buffer read address.
- `wwrite`  out  1  array weight-shift enable.
- `active`  out  1  array compute enable.
- `omem_wr_en`  out  1  output buffer write enable.
- `omem_addr`  out  ADDR_W  output buffer write address.

## Operation
- FSM states: IDLE, LOAD_W, COMPUTE, DRAIN, DONE.
- IDLE -> LOAD_W on `start`. Arguments are latched on the same edge.
- IDLE -> DONE when `start` arrives with `num_rows` == 0. The block pulses `done` and performs no memory or array activity.
- LOAD_W:
  - Lasts exactly N cycles.
  - `wmem_rd_en`=1 with `wmem_addr` = `weight_base` + i for i = 0..N-1.
  - Then -> COMPUTE.
- COMPUTE:
  - Lasts M cycles.
  - `imem_rd_en`=1 with `imem_addr` = `input_base` + r for r = 0..M-1.
  - Then -> DRAIN.
- DRAIN:
  - Holds until the last output write has issued, then -> DONE.
- DONE:
  - Lasts one cycle with `done`=1 and `busy`=0.
  - Then -> IDLE.
- Pipeline alignment, all relative to the buffer reads:
  - Buffers have 1-cycle read latency, so `wwrite` is `wmem_rd_en` delayed 1 cycle.
  - `active` is `imem_rd_en` delayed 1 cycle.
  - `omem_wr_en` is `active` delayed 2N cycles, with `omem_addr` = `output_base` + r.
- Address arithmetic is modulo 2^ADDR_W; base + offset wraps silently.
- `start` while `busy` is ignored; latched arguments are unchanged.
- `reset` at any time:
  - Next cycle the FSM is in IDLE, all counters and the delay line are cleared, and every output is 0.
  - No partial `done` pulse is issued.
- `busy` = 1 in LOAD_W, COMPUTE and DRAIN, else 0.

## Timing
- Cycle 0 is the IDLE cycle in which `start` is sampled high (M ≥ 1).
- `wmem_rd_en`: cycles 1..N.
- `wwrite`: cycles 2..N+1.
- `imem_rd_en`: cycles N+1..N+M.
- `active`: cycles N+2..N+M+1. `wwrite` and `active` are never high together.
- `omem_wr_en`: cycles 3N+2..3N+M+1.
- `busy`: cycles 1..3N+M+1.
- `done`: cycle 3N+M+2.
- Earliest next `start` is accepted in cycle 3N+M+3.
- M = 0: `done` in cycle 1 and `busy` stays 0.
- Reset values: all outputs 0, all address outputs 0.
- Address outputs are 0 whenever their enable is 0.

## Structure
- Package `sysarr_pkg`:
  - state enum `sysarr_state_t`.
  - localparams `RD_LAT` = 1 and `DRAIN_LAT` = 2*ARRAY_N.
  - counter width `CNT_W` = max(ADDR_W, $clog2(2*ARRAY_N+1)).
- Sub-module `sysarr_delay`:
  - Parameterised-depth shift register carrying `active` plus its row offset, producing the output write strobe and address.
  - Clears on `reset`.

## Test plan
- Reset, then N=4, M=3, all bases 0, `start` at cycle 0:
  - `wmem_addr` 0..3 in cycles 1–4.
  - `wwrite` high in cycles 2–5.
  - `imem_addr` 0..2 in cycles 5–7.
  - `active` high in cycles 6–8.
  - `omem_addr` 0..2 in cycles 14–16.
  - `done` in cycle 17.
- Wrap case, N=4, M=5, `input_base`=0xFE, `output_base`=0xFD:
  - `imem_addr` = FE, FF, 00, 01, 02.
  - `omem_addr` = FD, FE, FF, 00, 01.
- `num_rows`=0:
  - `done` in cycle 1.
  - No enable ever asserts.
- `start` pulsed again in cycle 6 with different bases:
  - Ignored; the original sequence completes unchanged.
- `reset` asserted in cycle 7 (COMPUTE):
  - Cycle 8: all outputs 0, no `done`.
  - A fresh `start` in cycle 9 runs a complete sequence.
- Back-to-back commands: second `start` in cycle 18 is accepted (N=4, M=3) and repeats the cycle-0 timing offset by 18.
